// File: rtl/fpga_dsp_pkg.sv
// Shared types and constants for the DSP-side FPGAtoDSPInt bus responder.
// Holds bus widths, the responder FSM state encoding and the unmapped-read fill value.
package fpga_dsp_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;

   localparam logic [DATA_W-1:0] RD_FILL_DEF = 8'hFF;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      DATA,
      HOLD,
      WAITREL
   } bus_state_t;

   function automatic logic is_mapped(input logic [ADDR_W-1:0] a,
                                      input int depth);
      return int'(a) < depth;
   endfunction

endpackage

// File: rtl/dsp_regfile.sv
// DEPTH x 8 register file: bus and core write ports (bus wins on a shared
// address), two asynchronous read ports, asynchronous clear.
// Ports: clk_i, rst_ni, bus_we_i/bus_addr_i/bus_wdata_i, bus_rdata_o,
//        core_we_i/core_addr_i/core_wdata_i, core_rdata_o.
module dsp_regfile
   import fpga_dsp_pkg::*;
#(
   parameter int                DEPTH   = 16,
   parameter logic [DATA_W-1:0] RD_FILL = RD_FILL_DEF
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              bus_we_i,
   input  logic [ADDR_W-1:0] bus_addr_i,
   input  logic [DATA_W-1:0] bus_wdata_i,
   output logic [DATA_W-1:0] bus_rdata_o,
   input  logic              core_we_i,
   input  logic [ADDR_W-1:0] core_addr_i,
   input  logic [DATA_W-1:0] core_wdata_i,
   output logic [DATA_W-1:0] core_rdata_o
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic          bus_ok;
   logic          core_ok;
   logic [IW-1:0] bus_idx;
   logic [IW-1:0] core_idx;

   assign bus_ok   = is_mapped(bus_addr_i, DEPTH);
   assign core_ok  = is_mapped(core_addr_i, DEPTH);
   assign bus_idx  = bus_addr_i[IW-1:0];
   assign core_idx = core_addr_i[IW-1:0];

   assign bus_rdata_o  = bus_ok  ? mem_q[bus_idx]  : RD_FILL;
   assign core_rdata_o = core_ok ? mem_q[core_idx] : RD_FILL;

   // Bus write is issued last so it overrides a core write to the same entry.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (core_we_i && core_ok) mem_q[core_idx] <= core_wdata_i;
         if (bus_we_i && bus_ok)   mem_q[bus_idx]  <= bus_wdata_i;
      end
   end

endmodule

// File: rtl/dsp_bus_responder.sv
// DSP-side responder for the FPGAtoDSPInt strobe bus: decodes N_CS/N_DS/R_NW
// cycles into register file accesses and forwards Start as a one-cycle pulse.
// Ports: Clk, N_Reset, N_CS, N_DS, R_NW, AddrBus, DataBusIn, DataBusOut,
//        DataBusOE, Start, CoreStart, CoreWrEn, CoreAddr, CoreWrData,
//        CoreRdData, BusWrPulse, Timeout.
// Optional watchdog: define DSP_RESP_TIMEOUT_EN.
module dsp_bus_responder
   import fpga_dsp_pkg::*;
#(
   parameter int                DEPTH   = 16,
   parameter int                TIMEOUT = 64,
   parameter logic [DATA_W-1:0] RD_FILL = RD_FILL_DEF
) (
   input  logic              Clk,
   input  logic              N_Reset,
   input  logic              N_CS,
   input  logic              N_DS,
   input  logic              R_NW,
   input  logic [ADDR_W-1:0] AddrBus,
   input  logic [DATA_W-1:0] DataBusIn,
   output logic [DATA_W-1:0] DataBusOut,
   output logic              DataBusOE,
   input  logic              Start,
   output logic              CoreStart,
   input  logic              CoreWrEn,
   input  logic [ADDR_W-1:0] CoreAddr,
   input  logic [DATA_W-1:0] CoreWrData,
   output logic [DATA_W-1:0] CoreRdData,
   output logic              BusWrPulse,
   output logic              Timeout
);

   bus_state_t        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              rnw_q, rnw_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              wr_q, wr_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              oe_q, oe_d;
   logic              start_q;
   logic [DATA_W-1:0] bus_rdata;

   dsp_regfile #(
      .DEPTH   (DEPTH),
      .RD_FILL (RD_FILL)
   ) u_regfile (
      .clk_i        (Clk),
      .rst_ni       (N_Reset),
      .bus_we_i     (wr_q),
      .bus_addr_i   (addr_q),
      .bus_wdata_i  (wdata_q),
      .bus_rdata_o  (bus_rdata),
      .core_we_i    (CoreWrEn),
      .core_addr_i  (CoreAddr),
      .core_wdata_i (CoreWrData),
      .core_rdata_o (CoreRdData)
   );

`ifdef DSP_RESP_TIMEOUT_EN
   logic [7:0] cnt_q;
   logic       tmo_q, tmo_d;
   logic       expire;

   assign expire = (state_q != IDLE) && (state_q != WAITREL)
                && (cnt_q == 8'(TIMEOUT - 1));

   always_ff @(posedge Clk or negedge N_Reset) begin
      if (!N_Reset) begin
         cnt_q <= '0;
         tmo_q <= 1'b0;
      end else begin
         cnt_q <= (state_q == IDLE || state_q == WAITREL) ? '0 : cnt_q + 8'd1;
         tmo_q <= tmo_d;
      end
   end

   assign Timeout = tmo_q;
`else
   assign Timeout = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rnw_d   = rnw_q;
      wdata_d = wdata_q;
      wr_d    = 1'b0;
      dout_d  = dout_q;
      oe_d    = oe_q;
`ifdef DSP_RESP_TIMEOUT_EN
      tmo_d   = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            oe_d = 1'b0;
            if (!N_CS) begin
               state_d = ADDR;
               addr_d  = AddrBus;
               rnw_d   = R_NW;
            end
         end
         ADDR: begin
            oe_d = 1'b0;
            if (N_CS) begin
               state_d = IDLE;
            end else if (!N_DS) begin
               state_d = DATA;
               if (rnw_q) begin
                  oe_d   = 1'b1;
                  dout_d = bus_rdata;
               end else begin
                  wr_d    = 1'b1;
                  wdata_d = DataBusIn;
               end
            end
         end
         DATA, HOLD: begin
            if (N_CS) begin
               state_d = IDLE;
               oe_d    = 1'b0;
            end else if (!N_DS) begin
               state_d = HOLD;
            end else begin
               // Next data phase reuses the latched address.
               state_d = ADDR;
               oe_d    = 1'b0;
            end
         end
`ifdef DSP_RESP_TIMEOUT_EN
         WAITREL: begin
            oe_d = 1'b0;
            if (N_CS) state_d = IDLE;
         end
`endif
         default: begin
            state_d = IDLE;
            oe_d    = 1'b0;
         end
      endcase
`ifdef DSP_RESP_TIMEOUT_EN
      if (expire) begin
         state_d = WAITREL;
         oe_d    = 1'b0;
         wr_d    = 1'b0;
         tmo_d   = 1'b1;
      end
`endif
   end

   always_ff @(posedge Clk or negedge N_Reset) begin
      if (!N_Reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         rnw_q   <= 1'b0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         dout_q  <= '0;
         oe_q    <= 1'b0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rnw_q   <= rnw_d;
         wdata_q <= wdata_d;
         wr_q    <= wr_d;
         dout_q  <= dout_d;
         oe_q    <= oe_d;
         start_q <= Start;
      end
   end

   assign DataBusOut = dout_q;
   assign DataBusOE  = oe_q;
   assign BusWrPulse = wr_q;
   assign CoreStart  = Start & ~start_q;

endmodule
